// File: rtl/simt_scheduler_if.sv
// Signal bundle between the SIMT scheduler and the rest of the core (fetcher, decoder, LSUs,
// PC units, ALUs/register files). The scheduler uses the slave modport.
interface simt_scheduler_if #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8,
    parameter int CNT_WIDTH         = 32
);
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

    logic                                    start;
    logic                                    decoded_mem_read_enable;
    logic                                    decoded_mem_write_enable;
    logic                                    decoded_ret;
    logic [2:0]                              fetcher_state;
    logic [2*THREADS_PER_BLOCK-1:0]          lsu_state;
    logic [PC_WIDTH*THREADS_PER_BLOCK-1:0]   next_pc;
    logic [TCW-1:0]                          thread_count;

    logic [PC_WIDTH-1:0]                     current_pc;
    logic [THREADS_PER_BLOCK-1:0]            active_mask;
    logic [2:0]                              core_state;
    logic                                    done;
    logic [CNT_WIDTH-1:0]                    cycle_count;
    logic [CNT_WIDTH-1:0]                    instr_count;
    logic [CNT_WIDTH-1:0]                    diverge_count;

    modport master (
        output start, decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret,
               fetcher_state, lsu_state, next_pc, thread_count,
        input  current_pc, active_mask, core_state, done, cycle_count, instr_count,
               diverge_count
    );

    modport slave (
        input  start, decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret,
               fetcher_state, lsu_state, next_pc, thread_count,
        output current_pc, active_mask, core_state, done, cycle_count, instr_count,
               diverge_count
    );
endinterface

// File: rtl/simt_scheduler.sv
// Per-core SIMT control-flow scheduler: sequences the instruction pipeline and issues each
// instruction to the live lanes sharing the minimum PC, giving reconvergence at join points.
module simt_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8,
    parameter int CNT_WIDTH         = 32
) (
    input logic          clk,
    input logic          reset_n,
    simt_scheduler_if.slave bus
);
    localparam int T   = THREADS_PER_BLOCK;
    localparam int TCW = $clog2(T) + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_REQUEST = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_EXECUTE = 3'd5;
    localparam logic [2:0] ST_UPDATE  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [2:0]           FETCHED = 3'b010;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [2:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  current_pc_q, current_pc_d;
    logic [T-1:0]         active_mask_q, active_mask_d;
    logic [T-1:0]         live_q, live_d;
    logic [PC_WIDTH-1:0]  thread_pc_q [T];
    logic [PC_WIDTH-1:0]  thread_pc_d [T];
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_WIDTH-1:0] diverge_q, diverge_d;

    logic [T-1:0]         lsu_busy;
    logic [PC_WIDTH-1:0]  min_pc;
    logic                 any_live;
    logic [PC_WIDTH-1:0]  ref_pc;
    logic                 ref_found;
    logic                 diverged;
    logic [PC_WIDTH-1:0]  lane_npc;

    // Memory-op flags are informational only; WAIT is gated purely by the LSU states.
    logic unused_mem_flags;
    assign unused_mem_flags = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

    always_comb begin
        for (int i = 0; i < T; i++) begin
            lsu_busy[i] = (bus.lsu_state[2*i +: 2] == 2'b01) ||
                          (bus.lsu_state[2*i +: 2] == 2'b10);
        end
    end

    always_comb begin
        state_d       = state_q;
        current_pc_d  = current_pc_q;
        active_mask_d = active_mask_q;
        live_d        = live_q;
        thread_pc_d   = thread_pc_q;
        done_d        = done_q;
        cycle_d       = cycle_q;
        instr_d       = instr_q;
        diverge_d     = diverge_q;
        min_pc        = '0;
        any_live      = 1'b0;
        ref_pc        = '0;
        ref_found     = 1'b0;
        diverged      = 1'b0;
        lane_npc      = '0;

        if (state_q != ST_IDLE && state_q != ST_DONE) begin
            cycle_d = cycle_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.thread_count != '0) begin
                        for (int i = 0; i < T; i++) begin
                            live_d[i]      = (TCW'(i) < bus.thread_count);
                            thread_pc_d[i] = '0;
                        end
                        current_pc_d  = '0;
                        active_mask_d = live_d;
                        state_d       = ST_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (bus.fetcher_state == FETCHED) state_d = ST_DECODE;
            end
            ST_DECODE:  state_d = ST_REQUEST;
            ST_REQUEST: state_d = ST_WAIT;
            ST_WAIT: begin
                if ((active_mask_q & lsu_busy) == '0) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: state_d = ST_UPDATE;
            ST_UPDATE: begin
                instr_d = instr_q + CNT_ONE;
                for (int i = 0; i < T; i++) begin
                    if (active_mask_q[i]) begin
                        lane_npc       = bus.next_pc[i*PC_WIDTH +: PC_WIDTH];
                        thread_pc_d[i] = lane_npc;
                        if (bus.decoded_ret) live_d[i] = 1'b0;
                        if (ref_found && (lane_npc != ref_pc)) diverged = 1'b1;
                        if (!ref_found) begin
                            ref_pc    = lane_npc;
                            ref_found = 1'b1;
                        end
                    end
                end
                // Pick the lowest PC among surviving lanes; every lane sitting there issues next.
                for (int i = 0; i < T; i++) begin
                    if (live_d[i] && (!any_live || (thread_pc_d[i] < min_pc))) begin
                        min_pc   = thread_pc_d[i];
                        any_live = 1'b1;
                    end
                end
                for (int i = 0; i < T; i++) begin
                    active_mask_d[i] = live_d[i] && (thread_pc_d[i] == min_pc);
                end
                if (!bus.decoded_ret && diverged) diverge_d = diverge_q + CNT_ONE;
                if (!any_live) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    current_pc_d = min_pc;
                    state_d      = ST_FETCH;
                end
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            current_pc_q  <= '0;
            active_mask_q <= '0;
            live_q        <= '0;
            done_q        <= 1'b0;
            cycle_q       <= '0;
            instr_q       <= '0;
            diverge_q     <= '0;
            for (int i = 0; i < T; i++) thread_pc_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            current_pc_q  <= current_pc_d;
            active_mask_q <= active_mask_d;
            live_q        <= live_d;
            done_q        <= done_d;
            cycle_q       <= cycle_d;
            instr_q       <= instr_d;
            diverge_q     <= diverge_d;
            for (int i = 0; i < T; i++) thread_pc_q[i] <= thread_pc_d[i];
        end
    end

    assign bus.current_pc    = current_pc_q;
    assign bus.active_mask   = active_mask_q;
    assign bus.core_state    = state_q;
    assign bus.done          = done_q;
    assign bus.cycle_count   = cycle_q;
    assign bus.instr_count   = instr_q;
    assign bus.diverge_count = diverge_q;
endmodule

// File: tb/tb_simt_scheduler.sv
// Directed scoreboard bench for simt_scheduler: expected issue groups are queued when a
// program is launched and checked each time the scheduler enters FETCH.
module tb_simt_scheduler;
    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] mask;
    } issue_t;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    int     checks = 0;
    int     errors = 0;
    issue_t exp_q[$];

    simt_scheduler_if #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8), .CNT_WIDTH(32)) bus ();

    simt_scheduler #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8), .CNT_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        int n = 0;
        while (bus.core_state !== st && n < 100) begin
            step();
            n++;
        end
        chk(tag, 64'(bus.core_state), 64'(st));
    endtask

    task automatic reset_dut();
        reset_n                      = 1'b0;
        bus.start                    = 1'b0;
        bus.decoded_mem_read_enable  = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
        bus.decoded_ret              = 1'b0;
        bus.fetcher_state            = 3'b010;
        bus.lsu_state                = '0;
        bus.next_pc                  = '0;
        bus.thread_count             = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic start_block(input logic [2:0] tc);
        bus.start        = 1'b1;
        bus.thread_count = tc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        issue_t e;
        chk({tag, "_in_fetch"}, 64'(bus.core_state), 64'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, 64'(bus.current_pc), 64'(e.pc));
            chk({tag, "_mask"}, 64'(bus.active_mask), 64'(e.mask));
        end
    endtask

    task automatic issue(input logic [31:0] np, input logic ret, input string tag);
        pop_check(tag);
        bus.next_pc     = np;
        bus.decoded_ret = ret;
        wait_state(3'd6, {tag, "_to_update"});
        step();
        bus.decoded_ret = 1'b0;
    endtask

    initial begin
        // Reset state
        reset_dut();
        chk("rst_state", 64'(bus.core_state), 64'd0);
        chk("rst_mask", 64'(bus.active_mask), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_cycles", 64'(bus.cycle_count), 64'd0);

        // Uniform flow, RET at PC 3
        exp_q.push_back('{pc: 8'd0, mask: 4'hF});
        exp_q.push_back('{pc: 8'd1, mask: 4'hF});
        exp_q.push_back('{pc: 8'd2, mask: 4'hF});
        exp_q.push_back('{pc: 8'd3, mask: 4'hF});
        start_block(3'd4);
        issue({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, "uni0");
        issue({8'd2, 8'd2, 8'd2, 8'd2}, 1'b0, "uni1");
        issue({8'd3, 8'd3, 8'd3, 8'd3}, 1'b0, "uni2");
        issue({8'd4, 8'd4, 8'd4, 8'd4}, 1'b1, "uni3");
        chk("uni_state", 64'(bus.core_state), 64'd7);
        chk("uni_done", 64'(bus.done), 64'd1);
        chk("uni_instr", 64'(bus.instr_count), 64'd4);
        chk("uni_div", 64'(bus.diverge_count), 64'd0);
        chk("uni_cycles", 64'(bus.cycle_count), 64'd24);
        bus.start        = 1'b1;
        bus.thread_count = 3'd4;
        step();
        bus.start = 1'b0;
        chk("done_ignores_start", 64'(bus.core_state), 64'd7);
        chk("done_cycles_frozen", 64'(bus.cycle_count), 64'd24);

        // Divergence and reconvergence
        reset_dut();
        exp_q.push_back('{pc: 8'd0, mask: 4'hF});
        exp_q.push_back('{pc: 8'd1, mask: 4'hF});
        exp_q.push_back('{pc: 8'd2, mask: 4'h3});
        exp_q.push_back('{pc: 8'd4, mask: 4'hF});
        start_block(3'd4);
        issue({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, "div0");
        issue({8'd4, 8'd4, 8'd2, 8'd2}, 1'b0, "div1");
        chk("div_count_split", 64'(bus.diverge_count), 64'd1);
        issue({8'hAA, 8'hBB, 8'd4, 8'd4}, 1'b0, "div2");
        chk("div_count_join", 64'(bus.diverge_count), 64'd1);
        issue({8'd5, 8'd5, 8'd5, 8'd5}, 1'b1, "div4");
        chk("div_done", 64'(bus.done), 64'd1);
        chk("div_instr", 64'(bus.instr_count), 64'd4);

        // Partial block; an idle lane stuck REQUESTING must not stall WAIT
        reset_dut();
        bus.lsu_state = 8'b0100_0000;
        exp_q.push_back('{pc: 8'd0, mask: 4'h3});
        exp_q.push_back('{pc: 8'd1, mask: 4'h3});
        start_block(3'd2);
        issue({8'd9, 8'd9, 8'd1, 8'd1}, 1'b0, "part0");
        issue({8'd9, 8'd9, 8'd2, 8'd2}, 1'b1, "part1");
        chk("part_done", 64'(bus.done), 64'd1);
        chk("part_cycles", 64'(bus.cycle_count), 64'd12);

        // LSU stall on active lane 1 plus a delayed fetch
        reset_dut();
        bus.fetcher_state = 3'b000;
        bus.lsu_state     = 8'b0000_1000;
        exp_q.push_back('{pc: 8'd0, mask: 4'hF});
        start_block(3'd4);
        pop_check("stall");
        step();
        chk("fetch_hold", 64'(bus.core_state), 64'd1);
        bus.fetcher_state = 3'b010;
        wait_state(3'd4, "stall_to_wait");
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("stall_wait%0d", k), 64'(bus.core_state), 64'd4);
        end
        bus.lsu_state = '0;
        step();
        chk("stall_exec", 64'(bus.core_state), 64'd5);
        bus.next_pc     = {8'd1, 8'd1, 8'd1, 8'd1};
        bus.decoded_ret = 1'b1;
        wait_state(3'd6, "stall_to_update");
        step();
        bus.decoded_ret = 1'b0;
        chk("stall_done", 64'(bus.done), 64'd1);
        chk("stall_cycles", 64'(bus.cycle_count), 64'd12);

        // Staggered RET
        reset_dut();
        exp_q.push_back('{pc: 8'd0, mask: 4'hF});
        exp_q.push_back('{pc: 8'd5, mask: 4'h3});
        exp_q.push_back('{pc: 8'd7, mask: 4'hC});
        start_block(3'd4);
        issue({8'd7, 8'd7, 8'd5, 8'd5}, 1'b0, "stag0");
        issue({8'd9, 8'd9, 8'd6, 8'd6}, 1'b1, "stag5");
        chk("stag_not_done", 64'(bus.done), 64'd0);
        issue({8'd8, 8'd8, 8'd8, 8'd8}, 1'b1, "stag7");
        chk("stag_done", 64'(bus.done), 64'd1);
        chk("stag_instr", 64'(bus.instr_count), 64'd3);
        chk("stag_div", 64'(bus.diverge_count), 64'd1);

        // Reset mid-WAIT, then a zero-thread launch
        reset_dut();
        bus.lsu_state = 8'b0000_0001;
        start_block(3'd4);
        wait_state(3'd4, "rw_to_wait");
        step();
        step();
        chk("rw_held", 64'(bus.core_state), 64'd4);
        reset_n = 1'b0;
        #1;
        chk("rw_state", 64'(bus.core_state), 64'd0);
        chk("rw_mask", 64'(bus.active_mask), 64'd0);
        chk("rw_pc", 64'(bus.current_pc), 64'd0);
        chk("rw_done", 64'(bus.done), 64'd0);
        chk("rw_cycles", 64'(bus.cycle_count), 64'd0);
        chk("rw_instr", 64'(bus.instr_count), 64'd0);
        bus.lsu_state = '0;
        step();
        reset_n = 1'b1;
        start_block(3'd0);
        chk("zero_state", 64'(bus.core_state), 64'd7);
        chk("zero_done", 64'(bus.done), 64'd1);
        chk("zero_instr", 64'(bus.instr_count), 64'd0);
        chk("zero_cycles", 64'(bus.cycle_count), 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simt_scheduler.md
# simt_scheduler

Per-core control-flow scheduler that sequences the FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE pipeline for one block and supports branch divergence. Each thread has its own PC. Every instruction issues to the group of live threads that share the minimum PC, which gives automatic reconvergence at join points. It sits in each core between the fetcher, decoder, LSUs and per-thread PC units, and drives `current_pc` and an `active_mask` consumed by ALUs, LSUs and register files.

## Interface
- `THREADS_PER_BLOCK`, default 4: thread lanes (≥1).
- `PC_WIDTH`, default 8: program counter width.
- `CNT_WIDTH`, default 32: performance counter width.

- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch block (sampled in IDLE).
- `decoded_mem_read_enable`  in  1  current instruction reads memory (informational; WAIT gating uses `lsu_state`).
- `decoded_mem_write_enable`  in  1  current instruction writes memory (informational).
- `decoded_ret`  in  1  current instruction is RET.
- `fetcher_state`  in  3  fetcher FSM; 3'b010 = FETCHED.
- `lsu_state`  in  2×THREADS_PER_BLOCK  per-lane LSU state; 2'b01 REQUESTING, 2'b10 WAITING.
- `next_pc`  in  PC_WIDTH×THREADS_PER_BLOCK  per-lane next PC from PC units, valid in UPDATE.
- `thread_count`  in  $clog2(THREADS_PER_BLOCK)+1  live lanes in block, sampled at start.
- `current_pc`  out  PC_WIDTH  PC of the issuing group.
- `active_mask`  out  THREADS_PER_BLOCK  lanes executing the current instruction.
- `core_state`  out  3  IDLE 0, FETCH 1, DECODE 2, REQUEST 3, WAIT 4, EXECUTE 5, UPDATE 6, DONE 7.
- `done`  out  1  block finished.
- `cycle_count`, `instr_count`, `diverge_count`  out  CNT_WIDTH each  performance counters.

## Operation
- Internal state:
  - `thread_pc[i]`: per-lane PC.
  - `thread_live[i]`: lane belongs to block and has not executed RET.
- IDLE:
  - On `start` with `thread_count` > 0:
    - `thread_live[i]` = (i < thread_count).
    - All `thread_pc` = 0; `current_pc` = 0.
    - `active_mask` = `thread_live`.
    - Go to FETCH.
  - On `start` with `thread_count` = 0: go to DONE, `done` = 1.
- FETCH: hold until `fetcher_state` == 3'b010, then go to DECODE.
- DECODE → REQUEST → WAIT: one cycle each.
- WAIT: hold while any lane with `active_mask[i]` = 1 has `lsu_state` of 01 or 10. Lanes with `active_mask` = 0 are ignored. Go to EXECUTE otherwise.
- EXECUTE → UPDATE: one cycle.
- UPDATE (one cycle):
  - For each active lane:
    - `thread_pc[i]` ← `next_pc[i]`.
    - If `decoded_ret`, `thread_live[i]` ← 0.
  - Inactive lanes keep their PC and live state.
  - Compute post-update live set L and post-update PCs.
  - If L is empty: `done` ← 1, go to DONE.
  - Otherwise:
    - `current_pc` ← min PC over L (unsigned).
    - `active_mask` ← lanes in L whose PC equals that minimum.
    - Go to FETCH.
  - Ties: all lanes at the minimum PC issue together.
- DONE: stays until reset; `start` is ignored.
- Counters:
  - `cycle_count` increments every cycle outside IDLE and DONE.
  - `instr_count` increments once per UPDATE.
  - `diverge_count` increments in UPDATE when `decoded_ret` = 0 and active lanes' `next_pc` values are not all equal.
  - All counters wrap modulo 2^CNT_WIDTH.

## Timing
- Reset (async, `reset_n` = 0) forces the following immediately; it is legal in any state and aborts a block mid-instruction:
  - `core_state` = IDLE.
  - `current_pc` = 0, `active_mask` = 0, `done` = 0, all counters = 0.
  - All `thread_pc` = 0, all `thread_live` = 0.
- Release is synchronous to the `clk` rising edge; the first IDLE sample of `start` occurs on the first edge after release.
- Minimum instruction latency is 6 cycles: FETCH (1 when fetcher already FETCHED), DECODE, REQUEST, WAIT (1), EXECUTE, UPDATE.
- `current_pc` and `active_mask` are registered. They change only on the IDLE→FETCH and UPDATE→FETCH edges and are stable from FETCH through UPDATE.
- `done` rises on the edge leaving UPDATE (or IDLE when `thread_count` = 0) and remains 1.
- `next_pc` and `decoded_ret` are sampled only in UPDATE; `lsu_state` only in WAIT; `fetcher_state` only in FETCH.

## Test plan
- Uniform flow, 4 threads: `next_pc` = PC+1 for all lanes, RET at PC 3.
  - `active_mask` = 4'b1111 throughout; PCs issued 0,1,2,3.
  - `done` = 1; `instr_count` = 4; `diverge_count` = 0.
- Divergence/reconvergence: at PC 1, lanes 0–1 get `next_pc` 2 and lanes 2–3 get 4. Lanes at PC 2 later go to 4.
  - Issue PC 2 with mask 0011; `diverge_count` = 1.
  - Then PC 4 with mask 1111 (reconverged).
- Partial block: `thread_count` = 2 with `THREADS_PER_BLOCK` = 4.
  - `active_mask` = 0011.
  - `lsu_state[3]` held at 01 must not stall WAIT.
- LSU stall: active lane 1 holds `lsu_state` = 10 for 5 cycles.
  - WAIT lasts exactly 6 cycles, then EXECUTE.
- Staggered RET: lanes 0–1 RET at PC 5 while lanes 2–3 sit at PC 7.
  - Next issue is PC 7 with mask 1100.
  - `done` rises only after their RET.
- Reset mid-WAIT, plus `thread_count` = 0 start:
  - Reset mid-WAIT: all outputs return to their reset values immediately.
  - `thread_count` = 0 start: IDLE→DONE in one cycle with `instr_count` = 0.
